// File: rtl/fetch_pkg.sv
// Shared fetch-path types and defaults.
// Used by the instruction fetch queue and its storage.
package fetch_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int KILL_DEF = 3;

  typedef struct packed {
    logic [DATA_W-1:0] ins;
    logic [ADDR_W-1:0] pc;
    logic              page_fault;
    logic              access_fault;
  } fetch_entry_t;

endpackage

// File: rtl/fq_mem.sv
// Fetch queue storage: DEPTH entries,
// one write port, asynchronous read.
module fq_mem
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fetch_entry_t  wdata,
  input  logic [AW-1:0] raddr,
  output fetch_entry_t  rdata
);

  fetch_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue between Icache and decode,
// with skid-based fetch stall and post-flush kill.
module ifetch_queue
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DEPTH      = 8,
  parameter int SKID       = 4,
  parameter int KILL_CNT   = KILL_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] INS_IN,
  input  logic [ADDR_WIDTH-1:0] PC_IN,
  input  logic                  INS_VALID,
  input  logic                  PAGE_FAULT_IN,
  input  logic                  ACCESS_FAULT_IN,
  input  logic                  FLUSH,
  output logic                  FETCH_STALL,
  output logic [DATA_WIDTH-1:0] INS_OUT,
  output logic [ADDR_WIDTH-1:0] PC_OUT,
  output logic                  PAGE_FAULT_OUT,
  output logic                  ACCESS_FAULT_OUT,
  output logic                  INS_OUT_VALID,
  input  logic                  DECODE_READY
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int KW = $clog2(KILL_CNT + 1);
  localparam logic [PW-1:0] THR = PW'(DEPTH - SKID);

  logic [PW-1:0] wptr, rptr, count;
  logic [KW-1:0] kill_cnt;
  logic          stall_q, overflow;
  logic          full, empty, killing;
  logic          push, pop, faulted;
  fetch_entry_t  wdata, rdata;

  assign count   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW])
                && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign killing = (kill_cnt != '0);
  assign push    = INS_VALID & ~full & ~FLUSH & ~killing;
  assign pop     = ~empty & DECODE_READY & ~FLUSH;
  assign faulted = PAGE_FAULT_IN | ACCESS_FAULT_IN;

  always_comb begin
    wdata              = '0;
    wdata.ins          = faulted ? '0 : INS_IN;
    wdata.pc           = PC_IN;
    wdata.page_fault   = PAGE_FAULT_IN;
    wdata.access_fault = ACCESS_FAULT_IN;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr     <= '0;
      rptr     <= '0;
      kill_cnt <= '0;
      stall_q  <= 1'b0;
      overflow <= 1'b0;
    end else if (FLUSH) begin
      wptr     <= '0;
      rptr     <= '0;
      kill_cnt <= KW'(KILL_CNT);
      stall_q  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (INS_VALID && killing) kill_cnt <= kill_cnt - 1'b1;
      if (INS_VALID && full && !killing) overflow <= 1'b1;
      // Threshold leaves SKID slots for fetches already in flight.
      stall_q <= ~killing & (count >= THR);
    end
  end

  fq_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (CLK),
    .we    (push),
    .waddr (wptr[AW-1:0]),
    .wdata (wdata),
    .raddr (rptr[AW-1:0]),
    .rdata (rdata)
  );

  assign FETCH_STALL      = stall_q;
  assign INS_OUT_VALID    = ~empty;
  assign INS_OUT          = rdata.ins;
  assign PC_OUT           = rdata.pc;
  assign PAGE_FAULT_OUT   = rdata.page_fault;
  assign ACCESS_FAULT_OUT = rdata.access_fault;

  ovf_sticky: assert property (
    @(posedge CLK) disable iff (RST || FLUSH) overflow |=> overflow
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: directed fetch
// traffic, head entries checked by a pop monitor.
module tb_ifetch_queue;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        pf;
    logic        af;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] INS_IN, PC_IN;
  logic        INS_VALID, PAGE_FAULT_IN, ACCESS_FAULT_IN;
  logic        FLUSH, FETCH_STALL;
  logic [31:0] INS_OUT, PC_OUT;
  logic        PAGE_FAULT_OUT, ACCESS_FAULT_OUT;
  logic        INS_OUT_VALID, DECODE_READY;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  ifetch_queue dut (
    .CLK              (CLK),
    .RST              (RST),
    .INS_IN           (INS_IN),
    .PC_IN            (PC_IN),
    .INS_VALID        (INS_VALID),
    .PAGE_FAULT_IN    (PAGE_FAULT_IN),
    .ACCESS_FAULT_IN  (ACCESS_FAULT_IN),
    .FLUSH            (FLUSH),
    .FETCH_STALL      (FETCH_STALL),
    .INS_OUT          (INS_OUT),
    .PC_OUT           (PC_OUT),
    .PAGE_FAULT_OUT   (PAGE_FAULT_OUT),
    .ACCESS_FAULT_OUT (ACCESS_FAULT_OUT),
    .INS_OUT_VALID    (INS_OUT_VALID),
    .DECODE_READY     (DECODE_READY)
  );

  always #5 CLK = ~CLK;

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ins_of(logic [31:0] pc);
    return 32'hC0DE0000 | {16'h0, pc[15:0]};
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic put(logic [31:0] pc, logic [31:0] ins,
                     logic pf, logic af, bit acc,
                     logic [31:0] eins);
    exp_t e;
    INS_VALID       = 1'b1;
    PC_IN           = pc;
    INS_IN          = ins;
    PAGE_FAULT_IN   = pf;
    ACCESS_FAULT_IN = af;
    if (acc) begin
      e.ins = eins; e.pc = pc; e.pf = pf; e.af = af;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    INS_VALID       = 1'b0;
    PAGE_FAULT_IN   = 1'b0;
    ACCESS_FAULT_IN = 1'b0;
  endtask

  // Pop monitor: every accepted head must match the scoreboard.
  always @(negedge CLK) begin
    if (!RST && INS_OUT_VALID && DECODE_READY && !FLUSH) begin
      if (sb.size() == 0) begin
        check("pop_unexpected", 64'(PC_OUT), 64'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pop_pc", 64'(PC_OUT), 64'(e.pc));
        check("pop_ins", 64'(INS_OUT), 64'(e.ins));
        check("pop_pf", 64'(PAGE_FAULT_OUT), 64'(e.pf));
        check("pop_af", 64'(ACCESS_FAULT_OUT), 64'(e.af));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; FLUSH = 1'b0; DECODE_READY = 1'b0;
    INS_IN = '0; PC_IN = '0;
    idle();
    #3;
    check("rst_valid", 64'(INS_OUT_VALID), 64'd0);
    check("rst_stall", 64'(FETCH_STALL), 64'd0);
    cyc(); cyc();
    RST = 1'b0;
    cyc();

    // Fill to full with decode blocked.
    for (int i = 0; i < 8; i++) begin
      put(32'(4*i), ins_of(32'(4*i)), 1'b0, 1'b0, 1'b1,
          ins_of(32'(4*i)));
      @(negedge CLK);
      if (i == 3) check("fill_stall_lo", 64'(FETCH_STALL), 64'd0);
      if (i >= 5) check("fill_stall_hi", 64'(FETCH_STALL), 64'd1);
      cyc();
    end
    put(32'h20, ins_of(32'h20), 1'b0, 1'b0, 1'b0, '0);
    @(negedge CLK);
    check("full_valid", 64'(INS_OUT_VALID), 64'd1);
    check("full_head", 64'(PC_OUT), 64'h0);
    cyc();
    idle();
    @(negedge CLK);
    check("drop_head", 64'(PC_OUT), 64'h0);
    check("overflow", 64'(dut.overflow), 64'd1);
    cyc();

    // Drain in order.
    DECODE_READY = 1'b1;
    for (int d = 0; d < 8; d++) begin
      @(negedge CLK);
      if (d == 0) check("drain_stall_hi", 64'(FETCH_STALL), 64'd1);
      if (d == 7) check("drain_stall_lo", 64'(FETCH_STALL), 64'd0);
      cyc();
    end
    DECODE_READY = 1'b0;
    @(negedge CLK);
    check("drain_empty", 64'(INS_OUT_VALID), 64'd0);
    cyc();

    // Stream 20 entries at steady count 3, across pointer wrap.
    for (int k = 0; k < 3; k++) begin
      put(32'h1000 + 32'(4*k), ins_of(32'h1000 + 32'(4*k)),
          1'b0, 1'b0, 1'b1, ins_of(32'h1000 + 32'(4*k)));
      cyc();
    end
    DECODE_READY = 1'b1;
    for (int k = 3; k < 20; k++) begin
      put(32'h1000 + 32'(4*k), ins_of(32'h1000 + 32'(4*k)),
          1'b0, 1'b0, 1'b1, ins_of(32'h1000 + 32'(4*k)));
      @(negedge CLK);
      if (k == 10) begin
        check("stream_count", 64'(dut.count), 64'd3);
        check("stream_stall", 64'(FETCH_STALL), 64'd0);
      end
      cyc();
    end
    idle();
    cyc(); cyc(); cyc();
    DECODE_READY = 1'b0;
    @(negedge CLK);
    check("stream_empty", 64'(INS_OUT_VALID), 64'd0);
    cyc();

    // Flush at count 5, then kill three stale responses.
    for (int k = 0; k < 5; k++) begin
      put(32'h200 + 32'(4*k), ins_of(32'h200 + 32'(4*k)),
          1'b0, 1'b0, 1'b1, '0);
      cyc();
    end
    idle();
    FLUSH = 1'b1;
    sb.delete();
    @(negedge CLK);
    check("flush_stall_before", 64'(FETCH_STALL), 64'd1);
    cyc();
    FLUSH = 1'b0;
    put(32'h100, ins_of(32'h100), 1'b0, 1'b0, 1'b0, '0);
    @(negedge CLK);
    check("flush_valid", 64'(INS_OUT_VALID), 64'd0);
    check("flush_stall", 64'(FETCH_STALL), 64'd0);
    cyc();
    put(32'h104, ins_of(32'h104), 1'b0, 1'b0, 1'b0, '0);
    cyc();
    put(32'h108, ins_of(32'h108), 1'b0, 1'b0, 1'b0, '0);
    cyc();
    put(32'h10C, ins_of(32'h10C), 1'b0, 1'b0, 1'b1,
        ins_of(32'h10C));
    cyc();
    idle();
    @(negedge CLK);
    check("kill_valid", 64'(INS_OUT_VALID), 64'd1);
    check("kill_head", 64'(PC_OUT), 64'h10C);
    cyc();
    DECODE_READY = 1'b1;
    cyc();
    DECODE_READY = 1'b0;
    @(negedge CLK);
    check("kill_empty", 64'(INS_OUT_VALID), 64'd0);
    cyc();

    // Fault entries carry a zero instruction.
    put(32'h2000, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 32'h0);
    cyc();
    put(32'h2004, 32'h12345678, 1'b0, 1'b1, 1'b1, 32'h0);
    cyc();
    idle();
    @(negedge CLK);
    check("fault_pc", 64'(PC_OUT), 64'h2000);
    check("fault_pf", 64'(PAGE_FAULT_OUT), 64'd1);
    check("fault_ins", 64'(INS_OUT), 64'h0);
    cyc();
    DECODE_READY = 1'b1;
    cyc(); cyc();
    DECODE_READY = 1'b0;
    cyc();

    // Asynchronous reset at count 6.
    for (int k = 0; k < 6; k++) begin
      put(32'h3000 + 32'(4*k), ins_of(32'h3000 + 32'(4*k)),
          1'b0, 1'b0, 1'b1, '0);
      cyc();
    end
    idle();
    @(negedge CLK);
    check("pre_rst_stall", 64'(FETCH_STALL), 64'd1);
    check("pre_rst_valid", 64'(INS_OUT_VALID), 64'd1);
    #2;
    RST = 1'b1;
    sb.delete();
    #1;
    check("async_rst_valid", 64'(INS_OUT_VALID), 64'd0);
    check("async_rst_stall", 64'(FETCH_STALL), 64'd0);
    cyc();
    RST = 1'b0;
    cyc();
    @(negedge CLK);
    check("post_rst_valid", 64'(INS_OUT_VALID), 64'd0);
    check("post_rst_ovf", 64'(dut.overflow), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
